// File: rtl/jump_addr_reg_if.sv
// Bus interface for jump_addr_reg: data-bus input, lane strobes, sequencer
// handshake, address-bus drive and LED mirror.
// The optional increment port pair (inc/carry) exists only when
// JUMP_ADDR_INC_EN is defined.
interface jump_addr_reg_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 2,
    parameter int ADDR_W    = DATA_W * NUM_BYTES
);
    logic [DATA_W-1:0]    data_in;
    logic [NUM_BYTES-1:0] ld_byte;
    logic                 seq_start;
    logic                 data_valid;
    logic                 sel_addr;
    logic                 seq_busy;
    logic                 seq_done;
    logic                 addr_oe;
    logic [ADDR_W-1:0]    addr_out;
    logic [ADDR_W-1:0]    content;
    logic [NUM_BYTES-1:0] led_ld;
    logic                 led_sel;
`ifdef JUMP_ADDR_INC_EN
    logic                 inc;
    logic                 carry;

    modport master (
        output data_in, ld_byte, seq_start, data_valid, sel_addr, inc,
        input  seq_busy, seq_done, addr_oe, addr_out, content, led_ld, led_sel, carry
    );
    modport slave (
        input  data_in, ld_byte, seq_start, data_valid, sel_addr, inc,
        output seq_busy, seq_done, addr_oe, addr_out, content, led_ld, led_sel, carry
    );
`else
    modport master (
        output data_in, ld_byte, seq_start, data_valid, sel_addr,
        input  seq_busy, seq_done, addr_oe, addr_out, content, led_ld, led_sel
    );
    modport slave (
        input  data_in, ld_byte, seq_start, data_valid, sel_addr,
        output seq_busy, seq_done, addr_oe, addr_out, content, led_ld, led_sel
    );
`endif
endinterface

// File: rtl/jump_addr_reg.sv
// jump_addr_reg: multi-byte jump-address register (successor to the J1
// register). Lanes load from the data bus by direct strobes or through a
// sequenced MS-lane-first load; the assembled address drives the shared
// wired-OR address bus on select and load/select activity is mirrored to
// the LED bus.
// Optional feature macro: JUMP_ADDR_INC_EN (adds inc input / carry output).
module jump_addr_reg #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 2,
    parameter int ADDR_W    = DATA_W * NUM_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    jump_addr_reg_if.slave  bus
);
    localparam int KW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [KW-1:0]        k;
    logic                 busy_q;
    logic                 done_q;
    logic                 oe_q;
    logic [ADDR_W-1:0]    content_q;
    logic [NUM_BYTES-1:0] led_q;

    logic                 start;
    logic [NUM_BYTES-1:0] seq_wr;
    logic [NUM_BYTES-1:0] dir_wr;
    logic [NUM_BYTES-1:0] wr;
    logic [ADDR_W-1:0]    content_nxt;
    logic [NUM_BYTES-1:0] led_nxt;

`ifdef JUMP_ADDR_INC_EN
    logic                 do_inc;
    logic [ADDR_W-1:0]    content_inc;
    logic                 carry_q;
`endif

    // Lane write decode and next-content selection (sequenced > direct > increment)
    always_comb begin
        start       = (state == IDLE) && bus.seq_start;
        seq_wr      = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if ((state == LOAD) && bus.data_valid && (k == KW'(i)))
                seq_wr[i] = 1'b1;
        end
        dir_wr      = (busy_q || start) ? '0 : bus.ld_byte;
        // Both write sources carry data_in, so OR-ing them keeps the priority intact.
        wr          = seq_wr | dir_wr;
        content_nxt = content_q;
        led_nxt     = wr;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (wr[i])
                content_nxt[i*DATA_W +: DATA_W] = bus.data_in;
        end
`ifdef JUMP_ADDR_INC_EN
        do_inc      = bus.inc && !busy_q && (wr == '0);
        content_inc = content_q + 1'b1;
        if (do_inc) begin
            content_nxt = content_inc;
            // An increment rewrites the lanes whose byte actually changes.
            for (int unsigned i = 0; i < NUM_BYTES; i++)
                led_nxt[i] = (content_inc[i*DATA_W +: DATA_W] != content_q[i*DATA_W +: DATA_W]);
        end
`endif
    end

    // Sequenced-load FSM with registered busy/done flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.seq_start) begin
                        state  <= LOAD;
                        k      <= KW'(NUM_BYTES - 1);
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.data_valid) begin
                        if (k == '0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            k <= k - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Content, LED mirror and bus-enable registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            content_q <= '0;
            led_q     <= '0;
            oe_q      <= 1'b0;
`ifdef JUMP_ADDR_INC_EN
            carry_q   <= 1'b0;
`endif
        end else begin
            content_q <= content_nxt;
            led_q     <= led_nxt;
            oe_q      <= bus.sel_addr & ~busy_q;
`ifdef JUMP_ADDR_INC_EN
            carry_q   <= do_inc && (&content_q);
`endif
        end
    end

    assign bus.seq_busy = busy_q;
    assign bus.seq_done = done_q;
    assign bus.addr_oe  = oe_q;
    assign bus.addr_out = oe_q ? content_q : '0;
    assign bus.content  = content_q;
    assign bus.led_ld   = led_q;
    assign bus.led_sel  = oe_q;
`ifdef JUMP_ADDR_INC_EN
    assign bus.carry    = carry_q;
`endif

endmodule

// File: tb/tb_jump_addr_reg.sv
// Self-checking bench for jump_addr_reg: default 2-lane instance plus a
// 3-lane instance; content expectations flow through a scoreboard queue.
// Increment tests are built only when JUMP_ADDR_INC_EN is defined.
module tb_jump_addr_reg;
    logic clk;
    logic reset;

    jump_addr_reg_if #(.DATA_W(8), .NUM_BYTES(2)) bus_a ();
    jump_addr_reg_if #(.DATA_W(8), .NUM_BYTES(3)) bus_b ();

    jump_addr_reg #(.DATA_W(8), .NUM_BYTES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    jump_addr_reg #(.DATA_W(8), .NUM_BYTES(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int errors;
    int checks;
    int done_a;
    int done_b;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count seq_done pulses away from the active edge
    always @(negedge clk) begin
        if (bus_a.seq_done) done_a++;
        if (bus_b.seq_done) done_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] got);
        sb_item_t it;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            it = sb.pop_front();
            check(it.tag, got, it.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        errors = 0; checks = 0; done_a = 0; done_b = 0;
        reset = 1'b1;
        bus_a.data_in = '0; bus_a.ld_byte = '0; bus_a.seq_start = 0;
        bus_a.data_valid = 0; bus_a.sel_addr = 0;
        bus_b.data_in = '0; bus_b.ld_byte = '0; bus_b.seq_start = 0;
        bus_b.data_valid = 0; bus_b.sel_addr = 0;
`ifdef JUMP_ADDR_INC_EN
        bus_a.inc = 0; bus_b.inc = 0;
`endif
        #2;
        check("rst_content", 32'(bus_a.content), 32'h0);
        check("rst_busy", 32'(bus_a.seq_busy), 32'h0);
        check("rst_addr_out", 32'(bus_a.addr_out), 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Direct lane loads
        bus_a.data_in = 8'hA5; bus_a.ld_byte = 2'b10;
        sb_push("direct_hi", 32'hA500);
        tick();
        sb_check(32'(bus_a.content));
        check("led_ld_hi", 32'(bus_a.led_ld), 32'h2);
        bus_a.data_in = 8'h3C; bus_a.ld_byte = 2'b01;
        sb_push("direct_lo", 32'hA53C);
        tick();
        sb_check(32'(bus_a.content));
        check("led_ld_lo", 32'(bus_a.led_ld), 32'h1);
        bus_a.ld_byte = 2'b00;
        tick();
        check("led_ld_idle", 32'(bus_a.led_ld), 32'h0);

        // Sequenced load with a 3-cycle gap and ignored direct strobes
        bus_a.seq_start = 1;
        tick();
        check("seq_busy_start", 32'(bus_a.seq_busy), 32'h1);
        bus_a.seq_start = 0;
        bus_a.data_valid = 1; bus_a.data_in = 8'h12; bus_a.ld_byte = 2'b11;
        sb_push("seq_first", 32'h123C);
        tick();
        sb_check(32'(bus_a.content));
        bus_a.data_valid = 0; bus_a.data_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_busy_gap", 32'(bus_a.seq_busy), 32'h1);
            check("seq_done_gap", 32'(bus_a.seq_done), 32'h0);
            check("seq_ld_ignored", 32'(bus_a.content), 32'h123C);
        end
        bus_a.ld_byte = 2'b00; bus_a.data_valid = 1; bus_a.data_in = 8'h34;
        sb_push("seq_final", 32'h1234);
        tick();
        sb_check(32'(bus_a.content));
        check("seq_done_pulse", 32'(bus_a.seq_done), 32'h1);
        check("seq_busy_done", 32'(bus_a.seq_busy), 32'h0);
        bus_a.data_valid = 0;
        tick();
        check("seq_done_clear", 32'(bus_a.seq_done), 32'h0);
        check("seq_done_count", 32'(done_a), 32'd1);

        // Address bus drive
        bus_a.data_in = 8'hBE; bus_a.ld_byte = 2'b10;
        tick();
        bus_a.data_in = 8'hEF; bus_a.ld_byte = 2'b01;
        sb_push("beef_load", 32'hBEEF);
        tick();
        sb_check(32'(bus_a.content));
        bus_a.ld_byte = 2'b00; bus_a.sel_addr = 1;
        check("bus_pre_sel", 32'(bus_a.addr_out), 32'h0);
        tick();
        check("bus_oe", 32'(bus_a.addr_oe), 32'h1);
        check("bus_addr", 32'(bus_a.addr_out), 32'hBEEF);
        check("bus_led_sel", 32'(bus_a.led_sel), 32'h1);
        bus_a.sel_addr = 0;
        tick();
        check("bus_release", 32'(bus_a.addr_out), 32'h0);
        bus_a.sel_addr = 1;
        tick();
        bus_a.data_in = 8'h00; bus_a.ld_byte = 2'b01;
        tick();
        check("bus_fresh", 32'(bus_a.addr_out), 32'hBE00);
        bus_a.ld_byte = 2'b00; bus_a.seq_start = 1;
        tick();
        bus_a.seq_start = 0;
        tick();
        check("bus_busy_oe", 32'(bus_a.addr_oe), 32'h0);
        check("bus_busy_out", 32'(bus_a.addr_out), 32'h0);
        check("bus_busy_flag", 32'(bus_a.seq_busy), 32'h1);

        // Reset while the sequencer is in LOAD
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_content", 32'(bus_a.content), 32'h0);
        check("mid_rst_busy", 32'(bus_a.seq_busy), 32'h0);
        check("mid_rst_led", 32'(bus_a.led_ld), 32'h0);
        check("mid_rst_oe", 32'(bus_a.addr_oe), 32'h0);
        tick(); tick();
        reset = 1'b0;
        bus_a.sel_addr = 0;
        tick();
        check("post_rst_busy", 32'(bus_a.seq_busy), 32'h0);
        check("post_rst_nodone", 32'(done_a), 32'd1);
        bus_a.data_valid = 1; bus_a.data_in = 8'h99;
        sb_push("idle_dv_ignored", 32'h0000);
        tick();
        sb_check(32'(bus_a.content));
        check("idle_dv_led", 32'(bus_a.led_ld), 32'h0);
        bus_a.data_valid = 0;

`ifdef JUMP_ADDR_INC_EN
        // Increment with wrap/carry and load-over-increment priority
        bus_a.data_in = 8'hFF; bus_a.ld_byte = 2'b11;
        tick();
        bus_a.ld_byte = 2'b00; bus_a.inc = 1;
        sb_push("inc_wrap", 32'h0000);
        tick();
        sb_check(32'(bus_a.content));
        check("inc_carry", 32'(bus_a.carry), 32'h1);
        sb_push("inc_one", 32'h0001);
        tick();
        sb_check(32'(bus_a.content));
        check("inc_carry_clear", 32'(bus_a.carry), 32'h0);
        bus_a.data_in = 8'hFF; bus_a.ld_byte = 2'b11;
        tick();
        bus_a.data_in = 8'h77; bus_a.ld_byte = 2'b01;
        sb_push("inc_load_wins", 32'hFF77);
        tick();
        sb_check(32'(bus_a.content));
        check("inc_load_carry", 32'(bus_a.carry), 32'h0);
        bus_a.inc = 0; bus_a.ld_byte = 2'b00;
        tick();
`endif

        // Three-lane sequenced load
        bus_b.seq_start = 1;
        tick();
        bus_b.seq_start = 0;
        bus_b.data_valid = 1;
        bus_b.data_in = 8'h01; tick();
        bus_b.data_in = 8'h02; tick();
        bus_b.data_in = 8'h03;
        sb_push("nb3_content", 32'h010203);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus_b.data_valid = 0;
            if (bus_b.seq_done) begin
                seen = 1;
                break;
            end
        end
        check("nb3_done_seen", 32'(seen), 32'h1);
        sb_check(32'(bus_b.content));
        tick(); tick();
        check("nb3_done_count", 32'(done_b), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
